// File: rtl/keypad_pkg.sv
// ============================================================================
// Package : keypad_pkg
// Brief   : Shared types, constants and helpers for the 4x4 keypad scanner.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN         = 3'd0,
    DEB_PRESS    = 3'd1,
    ACCEPT       = 3'd2,
    WAIT_RELEASE = 3'd3,
    DEB_RELEASE  = 3'd4
  } scan_state_t;

  localparam logic [3:0] COL_IDLE      = 4'b1110;
  localparam logic [3:0] ROWS_RELEASED = 4'b1111;

  // Index of the lowest active (0) row; the lowest row wins on multi-press.
  function automatic logic [1:0] lowest_zero_idx(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  // Active-low one-hot column strobe to column index.
  function automatic logic [1:0] col_to_idx(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Position {row,col} to keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_pos_to_digit(input logic [3:0] pos);
    logic [3:0] d;
    case (pos)
      4'h0: d = 4'h1;  4'h1: d = 4'h2;  4'h2: d = 4'h3;  4'h3: d = 4'hA;
      4'h4: d = 4'h4;  4'h5: d = 4'h5;  4'h6: d = 4'h6;  4'h7: d = 4'hB;
      4'h8: d = 4'h7;  4'h9: d = 4'h8;  4'hA: d = 4'h9;  4'hB: d = 4'hC;
      4'hC: d = 4'hE;  4'hD: d = 4'h0;  4'hE: d = 4'hF;  default: d = 4'hD;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module  : sync2
// Brief   : Parameterizable-width two-flop synchronizer for asynchronous pins.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_col_scanner.sv
// ============================================================================
// Module  : keypad_col_scanner
// Brief   : 4x4 keypad column scanner with press/release debounce and a
//           one-cycle key_valid strobe carrying the {row,col} position.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 27000,
  parameter int DEBOUNCE_TICKS = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_pos,
  output logic       key_valid,
  output logic       key_busy
);

  localparam int SW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_TICKS);
  localparam logic [SW-1:0] c_SLOT_LAST = SW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] c_DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

  logic [3:0]    w_rows_s;

  scan_state_t   r_state,    w_state_nxt;
  logic [SW-1:0] r_slot_cnt, w_slot_nxt;
  logic [DW-1:0] r_deb_cnt,  w_deb_nxt;
  logic [3:0]    r_col,      w_col_nxt;
  logic [1:0]    r_cand_row, w_cand_row_nxt;
  logic [1:0]    r_cand_col, w_cand_col_nxt;
  logic [3:0]    r_key_pos,  w_key_pos_nxt;
  logic [3:0]    w_col_rot;

  sync2 #(
    .WIDTH   (4),
    .RST_VAL (ROWS_RELEASED)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (fil),
    .o_q (w_rows_s)
  );

  assign w_col_rot = {r_col[2:0], r_col[3]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SCAN;
      r_slot_cnt <= '0;
      r_deb_cnt  <= '0;
      r_col      <= COL_IDLE;
      r_cand_row <= 2'd0;
      r_cand_col <= 2'd0;
      r_key_pos  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_slot_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_col      <= w_col_nxt;
      r_cand_row <= w_cand_row_nxt;
      r_cand_col <= w_cand_col_nxt;
      r_key_pos  <= w_key_pos_nxt;
    end
  end

  // Next-state logic: scan walk, press debounce, accept, release debounce.
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot_cnt;
    w_deb_nxt      = r_deb_cnt;
    w_col_nxt      = r_col;
    w_cand_row_nxt = r_cand_row;
    w_cand_col_nxt = r_cand_col;
    w_key_pos_nxt  = r_key_pos;

    case (r_state)
      SCAN: begin
        if (r_slot_cnt == c_SLOT_LAST) begin
          if (w_rows_s != ROWS_RELEASED) begin
            w_cand_row_nxt = lowest_zero_idx(w_rows_s);
            w_cand_col_nxt = col_to_idx(r_col);
            w_deb_nxt      = '0;
            w_state_nxt    = DEB_PRESS;
          end else begin
            w_col_nxt  = w_col_rot;
            w_slot_nxt = '0;
          end
        end else begin
          w_slot_nxt = r_slot_cnt + SW'(1);
        end
      end

      DEB_PRESS: begin
        if (w_rows_s[r_cand_row]) begin
          w_state_nxt = SCAN;
          w_col_nxt   = w_col_rot;
          w_slot_nxt  = '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          // Position is loaded on entry so it is valid alongside key_valid.
          w_key_pos_nxt = {r_cand_row, r_cand_col};
          w_state_nxt   = ACCEPT;
        end else begin
          w_deb_nxt = r_deb_cnt + DW'(1);
        end
      end

      ACCEPT: begin
        w_state_nxt = WAIT_RELEASE;
      end

      WAIT_RELEASE: begin
        if (w_rows_s == ROWS_RELEASED) begin
          w_deb_nxt   = '0;
          w_state_nxt = DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        if (w_rows_s != ROWS_RELEASED) begin
          w_state_nxt = WAIT_RELEASE;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt = SCAN;
          w_col_nxt   = w_col_rot;
          w_slot_nxt  = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DW'(1);
        end
      end

      default: begin
        w_state_nxt = SCAN;
      end
    endcase
  end

  assign col       = r_col;
  assign key_pos   = r_key_pos;
  assign key_valid = (r_state == ACCEPT);
  assign key_busy  = (r_state != SCAN);

endmodule

`default_nettype wire
